// File: rtl/aes_kat_vector_gen.sv
// AES known-answer / random / TVLA stimulus source feeding the AES core over a valid/ready handshake.
// Vectors are generated algorithmically (shift-in-ones sweeps, 128-bit Galois LFSR), so no ROM is needed.
module aes_kat_vector_gen #(
    parameter int KEY_WIDTH = 128,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] num_vectors,
    input  logic [127:0]         lfsr_seed,
    input  logic [KEY_WIDTH-1:0] fixed_key,
    input  logic [127:0]         fixed_text,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [127:0]         plainText,
    output logic [KEY_WIDTH-1:0] cypher_key,
    output logic [CNT_WIDTH-1:0] vec_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_VARTXT = 2'd0;
    localparam logic [1:0] MODE_VARKEY = 2'd1;
    localparam logic [1:0] MODE_RAND   = 2'd2;
    localparam logic [1:0] MODE_TVLA   = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Galois step for x^128 + x^7 + x^2 + x + 1
    function automatic logic [127:0] lfsr_step(input logic [127:0] s);
        lfsr_step = {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [1:0]             mode_r;
    logic [CNT_WIDTH-1:0]   num_r;
    logic [KEY_WIDTH-1:0]   fixed_key_r;
    logic [127:0]           fixed_text_r;
    logic [127:0]           lfsr_r;
    logic [CNT_WIDTH-1:0]   last_idx_r;

    logic [CNT_WIDTH-1:0]   n_s;
    logic                   out_valid_s;
    logic [127:0]           plaintext_s;
    logic [KEY_WIDTH-1:0]   key_s;
    logic [CNT_WIDTH-1:0]   idx_s;
    logic [127:0]           lfsr_s;
    logic [CNT_WIDTH-1:0]   last_idx_s;
    logic                   busy_s;
    logic                   done_s;

    // Vector count of the latched run
    always_comb begin
        case (mode_r)
            MODE_VARTXT: n_s = CNT_WIDTH'(32'd128);
            MODE_VARKEY: n_s = CNT_WIDTH'(KEY_WIDTH);
            default:     n_s = num_r;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (n_s == CNT_ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready && (vec_idx == last_idx_r)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Run configuration, captured only when a run is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r       <= 2'd0;
            num_r        <= CNT_ZERO;
            fixed_key_r  <= {KEY_WIDTH{1'b0}};
            fixed_text_r <= 128'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            mode_r       <= mode;
            num_r        <= num_vectors;
            fixed_key_r  <= fixed_key;
            fixed_text_r <= fixed_text;
        end else begin
            mode_r       <= mode_r;
            num_r        <= num_r;
            fixed_key_r  <= fixed_key_r;
            fixed_text_r <= fixed_text_r;
        end
    end

    // Output/datapath next values; every output is registered below
    always_comb begin
        out_valid_s = out_valid;
        plaintext_s = plainText;
        key_s       = cypher_key;
        idx_s       = vec_idx;
        lfsr_s      = lfsr_r;
        last_idx_s  = last_idx_r;
        busy_s      = (state_s == ST_LOAD) || (state_s == ST_EMIT);
        done_s      = (state_s == ST_DONE);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    lfsr_s = (lfsr_seed == 128'd0) ? 128'd1 : lfsr_seed;
                    idx_s  = CNT_ZERO;
                end else begin
                    lfsr_s = lfsr_r;
                end
            end
            ST_LOAD: begin
                if (n_s != CNT_ZERO) begin
                    out_valid_s = 1'b1;
                    idx_s       = CNT_ZERO;
                    last_idx_s  = n_s - CNT_ONE;
                    case (mode_r)
                        MODE_VARTXT: begin
                            plaintext_s = {1'b1, 127'd0};
                            key_s       = {KEY_WIDTH{1'b0}};
                        end
                        MODE_VARKEY: begin
                            plaintext_s = 128'd0;
                            key_s       = {1'b1, {(KEY_WIDTH-1){1'b0}}};
                        end
                        MODE_RAND: begin
                            plaintext_s = lfsr_r;
                            key_s       = fixed_key_r;
                        end
                        default: begin
                            plaintext_s = fixed_text_r;
                            key_s       = fixed_key_r;
                        end
                    endcase
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    // TVLA only consumes LFSR states on the odd (random) slots
                    if ((mode_r == MODE_RAND) || ((mode_r == MODE_TVLA) && vec_idx[0])) begin
                        lfsr_s = lfsr_step(lfsr_r);
                    end else begin
                        lfsr_s = lfsr_r;
                    end
                    if (vec_idx == last_idx_r) begin
                        out_valid_s = 1'b0;
                    end else begin
                        out_valid_s = 1'b1;
                        idx_s       = vec_idx + CNT_ONE;
                        case (mode_r)
                            MODE_VARTXT: plaintext_s = {1'b1, plainText[127:1]};
                            MODE_VARKEY: key_s = {1'b1, cypher_key[KEY_WIDTH-1:1]};
                            MODE_RAND:   plaintext_s = lfsr_step(lfsr_r);
                            MODE_TVLA:   plaintext_s = vec_idx[0] ? fixed_text_r : lfsr_r;
                            default:     plaintext_s = plainText;
                        endcase
                    end
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            ST_DONE: out_valid_s = 1'b0;
            default: out_valid_s = 1'b0;
        endcase
    end

    // Registered outputs and LFSR
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            plainText  <= 128'd0;
            cypher_key <= {KEY_WIDTH{1'b0}};
            vec_idx    <= CNT_ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
            lfsr_r     <= 128'd0;
            last_idx_r <= CNT_ZERO;
        end else begin
            out_valid  <= out_valid_s;
            plainText  <= plaintext_s;
            cypher_key <= key_s;
            vec_idx    <= idx_s;
            busy       <= busy_s;
            done       <= done_s;
            lfsr_r     <= lfsr_s;
            last_idx_r <= last_idx_s;
        end
    end

endmodule

// File: tb/tb_aes_kat_vector_gen.sv
// Randomised self-checking bench for aes_kat_vector_gen (KEY_WIDTH=256); expected vectors come
// from a queue-based reference built straight from the vector-generation rules.
module tb_aes_kat_vector_gen;

    localparam int KW = 256;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      mode;
    logic [CW-1:0]   num_vectors;
    logic [127:0]    lfsr_seed;
    logic [KW-1:0]   fixed_key;
    logic [127:0]    fixed_text;
    logic            out_ready;
    logic            out_valid;
    logic [127:0]    plainText;
    logic [KW-1:0]   cypher_key;
    logic [CW-1:0]   vec_idx;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    logic [127:0] cap_pt[$];
    logic [255:0] cap_key[$];

    aes_kat_vector_gen #(.KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .num_vectors (num_vectors),
        .lfsr_seed   (lfsr_seed),
        .fixed_key   (fixed_key),
        .fixed_text  (fixed_text),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .plainText   (plainText),
        .cypher_key  (cypher_key),
        .vec_idx     (vec_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Multiplication by x modulo x^128+x^7+x^2+x+1
    function automatic logic [127:0] mul_x(input logic [127:0] s);
        return {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_vectors(input logic [1:0] m, input int nv, input logic [127:0] seed,
                               input logic [255:0] fk, input logic [127:0] ft,
                               input int ready_pct, input bit poke);
        logic [127:0] exp_pt[$];
        logic [255:0] exp_key[$];
        logic [127:0] lf[$];
        logic [127:0] s;
        logic [127:0] ones128;
        logic [255:0] ones256;
        logic [127:0] hold_pt;
        logic [255:0] hold_key;
        logic [CW-1:0] hold_idx;
        int n, got, cyc, last_hs;
        bit stall, done_seen;
        ones128 = '1;
        ones256 = '1;
        n = (m == 2'd0) ? 128 : (m == 2'd1) ? KW : nv;
        s = (seed == 128'd0) ? 128'd1 : seed;
        for (int k = 0; k < n; k++) begin
            lf.push_back(s);
            s = mul_x(s);
        end
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0: begin exp_pt.push_back(~(ones128 >> (i + 1))); exp_key.push_back(256'd0); end
                2'd1: begin exp_pt.push_back(128'd0); exp_key.push_back(~(ones256 >> (i + 1))); end
                2'd2: begin exp_pt.push_back(lf[i]); exp_key.push_back(fk); end
                default: begin
                    exp_pt.push_back((i % 2 == 0) ? ft : lf[(i - 1) / 2]);
                    exp_key.push_back(fk);
                end
            endcase
        end
        cap_pt.delete();
        cap_key.delete();

        @(negedge clk);
        mode = m; num_vectors = nv[CW-1:0]; lfsr_seed = seed;
        fixed_key = fk; fixed_text = ft; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("load_busy", 256'(busy), 256'(1));
        check_eq("load_valid", 256'(out_valid), 256'(0));

        got = 0; cyc = 0; last_hs = 0; stall = 1'b0; done_seen = 1'b0;
        hold_pt = '0; hold_key = '0; hold_idx = '0;
        while (!done_seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin start = 1'b1; mode = 2'd0; end
            if (poke && cyc == 3) start = 1'b0;
            if (cyc == 1) check_eq("first_valid", 256'(out_valid), 256'(n > 0));
            if (stall) begin
                check_eq("hold_valid", 256'(out_valid), 256'(1));
                check_eq("hold_pt", 256'(plainText), 256'(hold_pt));
                check_eq("hold_key", cypher_key, hold_key);
                check_eq("hold_idx", 256'(vec_idx), 256'(hold_idx));
            end
            if (out_valid) begin
                check_eq("busy_emit", 256'(busy), 256'(1));
                out_ready = ($urandom_range(99) < ready_pct);
                if (out_ready) begin
                    if (got < n) begin
                        check_eq("vec_pt", 256'(plainText), 256'(exp_pt[got]));
                        check_eq("vec_key", cypher_key, exp_key[got]);
                        check_eq("vec_idx", 256'(vec_idx), 256'(got));
                        cap_pt.push_back(plainText);
                        cap_key.push_back(cypher_key);
                    end else begin
                        check_eq("extra_vector", 256'(got + 1), 256'(n));
                    end
                    got++;
                    last_hs = cyc;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    hold_pt = plainText; hold_key = cypher_key; hold_idx = vec_idx;
                end
            end else begin
                stall = 1'b0;
                out_ready = 1'($urandom_range(1));
            end
            if (done) begin
                done_seen = 1'b1;
                check_eq("vector_count", 256'(got), 256'(n));
                check_eq("done_timing", 256'(cyc), 256'((n == 0) ? 1 : last_hs + 1));
                check_eq("done_valid", 256'(out_valid), 256'(0));
                check_eq("done_busy", 256'(busy), 256'(0));
            end
        end
        if (!done_seen) check_eq("done_timeout", 256'(0), 256'(1));
        @(negedge clk);
        check_eq("done_pulse_len", 256'(done), 256'(0));
        check_eq("idle_busy", 256'(busy), 256'(0));
        if (ready_pct == 100 && n > 0) check_eq("back_to_back", 256'(last_hs), 256'(n));
    endtask

    initial begin
        logic [127:0] ft;
        logic [255:0] fk;
        logic [255:0] ones256;
        ones256 = '1;
        reset = 1'b1; start = 1'b0; mode = 2'd0; num_vectors = '0; lfsr_seed = '0;
        fixed_key = '0; fixed_text = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 256'(out_valid), 256'(0));
        check_eq("rst_pt", 256'(plainText), 256'(0));
        check_eq("rst_key", cypher_key, 256'(0));
        check_eq("rst_idx", 256'(vec_idx), 256'(0));
        check_eq("rst_busy", 256'(busy), 256'(0));
        check_eq("rst_done", 256'(done), 256'(0));
        reset = 1'b0;

        run_vectors(2'd0, 0, 128'd0, 256'd0, 128'd0, 100, 1'b0);
        check_eq("vartxt_v0", 256'(cap_pt[0]), 256'(128'h8000_0000_0000_0000_0000_0000_0000_0000));
        check_eq("vartxt_v2", 256'(cap_pt[2]), 256'(128'hE000_0000_0000_0000_0000_0000_0000_0000));
        check_eq("vartxt_v127", 256'(cap_pt[127]), ones256 >> 128);

        run_vectors(2'd1, 0, 128'd0, 256'd0, 128'd0, 100, 1'b0);
        check_eq("varkey_v0", cap_key[0], {1'b1, 255'd0});
        check_eq("varkey_v255", cap_key[255], ones256);
        check_eq("varkey_pt", 256'(cap_pt[5]), 256'(0));

        fk = {rand128(), rand128()};
        ft = rand128();
        run_vectors(2'd2, 3, 128'd1, fk, ft, 100, 1'b0);
        check_eq("rand_s1_v2", 256'(cap_pt[2]), 256'(4));
        run_vectors(2'd2, 3, 128'd0, fk, ft, 100, 1'b0);
        check_eq("rand_s0_v1", 256'(cap_pt[1]), 256'(2));
        run_vectors(2'd2, 3, 128'h8000_0000_0000_0000_0000_0000_0000_0000, fk, ft, 100, 1'b0);
        check_eq("rand_msb_v1", 256'(cap_pt[1]), 256'(128'h87));
        run_vectors(2'd3, 4, 128'd1, fk, ft, 100, 1'b0);
        check_eq("tvla_v2", 256'(cap_pt[2]), 256'(ft));
        check_eq("tvla_v3", 256'(cap_pt[3]), 256'(2));

        run_vectors(2'd2, 0, rand128(), fk, ft, 100, 1'b0);
        run_vectors(2'd2, 8, rand128(), fk, ft, 100, 1'b1);

        run_vectors(2'd2, 40, rand128(), {rand128(), rand128()}, rand128(), 50, 1'b0);
        run_vectors(2'd3, 31, rand128(), {rand128(), rand128()}, rand128(), 60, 1'b0);
        run_vectors(2'd0, 0, 128'd0, 256'd0, 128'd0, 40, 1'b0);
        run_vectors(2'd1, 0, 128'd0, 256'd0, 128'd0, 70, 1'b0);

        // Reset while a vector is being presented
        @(negedge clk);
        mode = 2'd0; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_reset_valid", 256'(out_valid), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_valid", 256'(out_valid), 256'(0));
        check_eq("midrst_pt", 256'(plainText), 256'(0));
        check_eq("midrst_key", cypher_key, 256'(0));
        check_eq("midrst_idx", 256'(vec_idx), 256'(0));
        check_eq("midrst_busy", 256'(busy), 256'(0));
        check_eq("midrst_done", 256'(done), 256'(0));
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 256'(busy), 256'(0));
        run_vectors(2'd3, 5, rand128(), {rand128(), rand128()}, rand128(), 50, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
